// File: rtl/bf16_range_index_pipe.sv
// Two-stage valid/ready pipeline mapping a bfloat16 magnitude onto an
// octave-segmented LUT index, with tag passthrough and saturating event counters.
module bf16_range_index_pipe #(
  parameter int IDX_W   = 5,
  parameter int MAX_EXP = 128,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             cfg_neg_clamp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_neg,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] neg_cnt
);

  localparam int               SH_W    = $clog2(IDX_W);
  localparam logic [8:0]       TOP_E   = 9'(MAX_EXP);
  localparam logic [8:0]       LOW_E   = 9'(MAX_EXP - IDX_W + 1);
  localparam logic [SH_W-1:0]  TOP_LO  = SH_W'(MAX_EXP);
  localparam logic [3:0]       SH_BASE = 4'(8 - IDX_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Handshake: a word moves across an interface when valid && ready on the
  // same rising edge. A stage loads whenever it is empty or its downstream
  // stage is loading; in_ready is that S1 enable, so it depends on out_ready.
  logic en1, en2, out_hs;

  logic             s1_v_q, s1_v_d;
  logic             s1_ovf_q, s1_ovf_d;
  logic             s1_unf_q, s1_unf_d;
  logic [SH_W-1:0]  s1_d_q, s1_d_d;
  logic [6:0]       s1_mant_q, s1_mant_d;
  logic             s1_neg_q, s1_neg_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_clamp_q, s1_clamp_d;

  logic             s2_v_q, s2_v_d;
  logic [IDX_W-1:0] s2_index_q, s2_index_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic             s2_unf_q, s2_unf_d;
  logic             s2_neg_q, s2_neg_d;

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] neg_cnt_q, neg_cnt_d;

  logic [8:0]       e9;
  logic [IDX_W-1:0] seg_idx;
  logic [IDX_W-1:0] idx_asm;

  always_comb begin
    en2    = !s2_v_q || out_ready;
    en1    = !s1_v_q || en2;
    out_hs = s2_v_q && out_ready;
    e9     = {1'b0, in_x[14:7]};
  end

  // Stage 1: classify the exponent; d only needs its low bits since it is
  // consumed solely when the word lies inside the indexed range.
  always_comb begin
    s1_v_d     = s1_v_q;
    s1_ovf_d   = s1_ovf_q;
    s1_unf_d   = s1_unf_q;
    s1_d_d     = s1_d_q;
    s1_mant_d  = s1_mant_q;
    s1_neg_d   = s1_neg_q;
    s1_tag_d   = s1_tag_q;
    s1_clamp_d = s1_clamp_q;
    if (en1) begin
      s1_v_d     = in_valid;
      s1_ovf_d   = e9 > TOP_E;
      s1_unf_d   = e9 < LOW_E;
      s1_d_d     = TOP_LO - in_x[7 +: SH_W];
      s1_mant_d  = in_x[6:0];
      s1_neg_d   = in_x[15];
      s1_tag_d   = in_tag;
      s1_clamp_d = cfg_neg_clamp;
    end
  end

  // Stage 2: the hidden one plus leading mantissa bits, shifted down by octave.
  always_comb begin
    seg_idx = IDX_W'({1'b1, s1_mant_q} >> (SH_BASE + 4'(s1_d_q)));
    if (s1_clamp_q && s1_neg_q) begin
      idx_asm = '0;
    end else if (s1_ovf_q) begin
      idx_asm = '1;
    end else if (s1_unf_q) begin
      idx_asm = '0;
    end else begin
      idx_asm = seg_idx;
    end
  end

  always_comb begin
    s2_v_d     = s2_v_q;
    s2_index_d = s2_index_q;
    s2_tag_d   = s2_tag_q;
    s2_ovf_d   = s2_ovf_q;
    s2_unf_d   = s2_unf_q;
    s2_neg_d   = s2_neg_q;
    if (en2) begin
      s2_v_d     = s1_v_q;
      s2_index_d = idx_asm;
      s2_tag_d   = s1_tag_q;
      s2_ovf_d   = s1_ovf_q;
      s2_unf_d   = s1_unf_q;
      s2_neg_d   = s1_neg_q;
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    neg_cnt_d = neg_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d = '0;
      neg_cnt_d = '0;
    end else begin
      if (out_hs && s2_ovf_q && ovf_cnt_q != CNT_MAX) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      if (out_hs && s2_neg_q && neg_cnt_q != CNT_MAX) neg_cnt_d = neg_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_unf_q   <= 1'b0;
      s1_d_q     <= '0;
      s1_mant_q  <= '0;
      s1_neg_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_clamp_q <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_index_q <= '0;
      s2_tag_q   <= '0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_neg_q   <= 1'b0;
      ovf_cnt_q  <= '0;
      neg_cnt_q  <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_ovf_q   <= s1_ovf_d;
      s1_unf_q   <= s1_unf_d;
      s1_d_q     <= s1_d_d;
      s1_mant_q  <= s1_mant_d;
      s1_neg_q   <= s1_neg_d;
      s1_tag_q   <= s1_tag_d;
      s1_clamp_q <= s1_clamp_d;
      s2_v_q     <= s2_v_d;
      s2_index_q <= s2_index_d;
      s2_tag_q   <= s2_tag_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_unf_q   <= s2_unf_d;
      s2_neg_q   <= s2_neg_d;
      ovf_cnt_q  <= ovf_cnt_d;
      neg_cnt_q  <= neg_cnt_d;
    end
  end

  assign in_ready  = en1;
  assign out_valid = s2_v_q;
  assign out_index = s2_index_q;
  assign out_tag   = s2_tag_q;
  assign out_ovf   = s2_ovf_q;
  assign out_unf   = s2_unf_q;
  assign out_neg   = s2_neg_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign neg_cnt   = neg_cnt_q;

endmodule

// File: tb/tb_bf16_range_index_pipe.sv
// Bench for bf16_range_index_pipe: default instance plus an IDX_W=3/MAX_EXP=127/CNT_W=2
// instance, checked against a real-valued model of the segmented index.
`timescale 1ns/1ps
module tb_bf16_range_index_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- unit A (defaults) ----------------
  logic        a_iv, a_ir, a_clamp, a_ov, a_ordy, a_clr, a_fo, a_fu, a_fn;
  logic [15:0] a_x;
  logic [3:0]  a_tag, a_otag;
  logic [4:0]  a_idx;
  logic [15:0] a_oc, a_nc;

  bf16_range_index_pipe u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir), .in_x(a_x), .in_tag(a_tag),
    .cfg_neg_clamp(a_clamp),
    .out_valid(a_ov), .out_ready(a_ordy), .out_index(a_idx), .out_tag(a_otag),
    .out_ovf(a_fo), .out_unf(a_fu), .out_neg(a_fn),
    .cnt_clr(a_clr), .ovf_cnt(a_oc), .neg_cnt(a_nc)
  );

  // ---------------- unit B (small index, tiny counters) ----------------
  logic        b_iv, b_ir, b_clamp, b_ov, b_ordy, b_clr, b_fo, b_fu, b_fn;
  logic [15:0] b_x;
  logic [3:0]  b_tag, b_otag;
  logic [2:0]  b_idx;
  logic [1:0]  b_oc, b_nc;

  bf16_range_index_pipe #(.IDX_W(3), .MAX_EXP(127), .TAG_W(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir), .in_x(b_x), .in_tag(b_tag),
    .cfg_neg_clamp(b_clamp),
    .out_valid(b_ov), .out_ready(b_ordy), .out_index(b_idx), .out_tag(b_otag),
    .out_ovf(b_fo), .out_unf(b_fu), .out_neg(b_fn),
    .cnt_clr(b_clr), .ovf_cnt(b_oc), .neg_cnt(b_nc)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [14:0] exp_q[2][$];   // {index[7:0], tag[3:0], ovf, unf, neg}
  int          stamp_q[2][$];
  int          m_ovf[2];
  int          m_neg[2];
  bit          lat_mode[2];
  bit          a_saw_stall;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Index = floor(|x| * 2^(IDX_W - top_octave_exponent - 1)), clamped to the range.
  function automatic logic [14:0] model(input logic [15:0] x, input logic clamp,
                                        input logic [3:0] tag, input int idx_w, input int max_exp);
    int   e, idx;
    real  mag;
    logic o, un;
    e   = int'(x[14:7]);
    o   = (e > max_exp);
    un  = (e < max_exp - idx_w + 1);
    mag = real'(128 + int'(x[6:0])) * (2.0 ** (e - 134));
    if (o)       idx = (1 << idx_w) - 1;
    else if (un) idx = 0;
    else         idx = $rtoi(mag * (2.0 ** (idx_w + 126 - max_exp)));
    if (clamp && x[15]) idx = 0;
    return {8'(idx), tag, o, un, x[15]};
  endfunction

  task automatic pin(input string name, input logic [15:0] x, input logic clamp,
                     input int idx_w, input int max_exp, input logic [14:0] want);
    check(name, 32'(model(x, clamp, 4'd0, idx_w, max_exp)), 32'(want));
  endtask

  // One compare step per unit per cycle, at the falling edge.
  task automatic unit_step(input int u, input int idx_w, input int max_exp, input int cmax,
                           input logic iv, input logic ir, input logic [15:0] x,
                           input logic [3:0] tin, input logic cl,
                           input logic ov, input logic ordy, input logic [7:0] idx,
                           input logic [3:0] tg, input logic fo, input logic fu, input logic fn,
                           input logic clr, input logic [31:0] oc, input logic [31:0] nc);
    logic [14:0] e;
    if (rst) begin
      exp_q[u].delete();
      stamp_q[u].delete();
      m_ovf[u] = 0;
      m_neg[u] = 0;
      return;
    end
    check($sformatf("u%0d_ovf_cnt", u), oc, m_ovf[u]);
    check($sformatf("u%0d_neg_cnt", u), nc, m_neg[u]);
    if (iv && ir) begin
      exp_q[u].push_back(model(x, cl, tin, idx_w, max_exp));
      stamp_q[u].push_back(cyc);
    end
    if (ov) begin
      check($sformatf("u%0d_out_expected", u), 32'(exp_q[u].size() > 0), 1);
      if (exp_q[u].size() > 0) begin
        e = exp_q[u][0];
        check($sformatf("u%0d_out_word", u), 32'({idx, tg, fo, fu, fn}), 32'(e));
        if (ordy) begin
          if (lat_mode[u]) check($sformatf("u%0d_latency", u), cyc - stamp_q[u][0], 2);
          void'(exp_q[u].pop_front());
          void'(stamp_q[u].pop_front());
          if (e[2] && m_ovf[u] < cmax) m_ovf[u]++;
          if (e[0] && m_neg[u] < cmax) m_neg[u]++;
        end
      end
    end
    if (clr) begin
      m_ovf[u] = 0;
      m_neg[u] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (a_iv && !a_ir && !rst) a_saw_stall = 1'b1;
    unit_step(0, 5, 128, 65535, a_iv, a_ir, a_x, a_tag, a_clamp,
              a_ov, a_ordy, {3'b0, a_idx}, a_otag, a_fo, a_fu, a_fn,
              a_clr, {16'b0, a_oc}, {16'b0, a_nc});
    unit_step(1, 3, 127, 3, b_iv, b_ir, b_x, b_tag, b_clamp,
              b_ov, b_ordy, {5'b0, b_idx}, b_otag, b_fo, b_fu, b_fn,
              b_clr, {30'b0, b_oc}, {30'b0, b_nc});
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [15:0] x, input logic [3:0] t, input logic c);
    int n;
    n = 0;
    a_iv = 1'b1; a_x = x; a_tag = t; a_clamp = c;
    @(negedge clk);
    while (!a_ir && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("a_accept", 32'(a_ir), 1);
    @(posedge clk);
    #1;
    a_iv = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] x, input logic [3:0] t, input logic c);
    int n;
    n = 0;
    b_iv = 1'b1; b_x = x; b_tag = t; b_clamp = c;
    @(negedge clk);
    while (!b_ir && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("b_accept", 32'(b_ir), 1);
    @(posedge clk);
    #1;
    b_iv = 1'b0;
  endtask

  logic [15:0] bp_x[8] = '{16'h4040, 16'h4080, 16'hC040, 16'h3FC0,
                           16'h7FC0, 16'h3E00, 16'h3F20, 16'h407F};

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    a_iv = 0; a_x = '0; a_tag = '0; a_clamp = 0; a_ordy = 1; a_clr = 0;
    b_iv = 0; b_x = '0; b_tag = '0; b_clamp = 0; b_ordy = 1; b_clr = 0;
    lat_mode[0] = 1'b1;
    lat_mode[1] = 1'b1;
    a_saw_stall = 1'b0;

    // Hand-computed expectations pinning the model.
    pin("pin_3p0",     16'h4040, 0, 5, 128, {8'd24, 4'd0, 3'b000});
    pin("pin_0p625",   16'h3F20, 0, 5, 128, {8'd5,  4'd0, 3'b000});
    pin("pin_0p125",   16'h3E00, 0, 5, 128, {8'd1,  4'd0, 3'b000});
    pin("pin_0p0625",  16'h3D80, 0, 5, 128, {8'd0,  4'd0, 3'b010});
    pin("pin_4p0",     16'h4080, 0, 5, 128, {8'd31, 4'd0, 3'b100});
    pin("pin_3p984",   16'h407F, 0, 5, 128, {8'd31, 4'd0, 3'b000});
    pin("pin_nan",     16'h7FC0, 0, 5, 128, {8'd31, 4'd0, 3'b100});
    pin("pin_neg_clp", 16'hC040, 1, 5, 128, {8'd0,  4'd0, 3'b001});
    pin("pin_neg_mag", 16'hC040, 0, 5, 128, {8'd24, 4'd0, 3'b001});
    pin("pin_b_1p75",  16'h3FE0, 0, 3, 127, {8'd7,  4'd0, 3'b000});
    pin("pin_b_0p3",   16'h3E9A, 0, 3, 127, {8'd1,  4'd0, 3'b000});
    pin("pin_b_0p2",   16'h3E4D, 0, 3, 127, {8'd0,  4'd0, 3'b010});

    #12;
    check("a_rst_outs", 32'({a_ov, a_idx, a_otag, a_fo, a_fu, a_fn}), 0);
    check("a_rst_cnts", {a_oc, a_nc}, 0);
    check("b_rst_outs", 32'({b_ov, b_idx, b_otag, b_fo, b_fu, b_fn}), 0);
    check("b_rst_cnts", 32'({b_oc, b_nc}), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("a_in_ready_after_rst", 32'(a_ir), 1);
    check("b_in_ready_after_rst", 32'(b_ir), 1);
    idle(1);

    // Main function and range edges, streamed back to back.
    send_a(16'h4040, 4'd0, 0);
    send_a(16'h3FC0, 4'd1, 0);
    send_a(16'h3F20, 4'd2, 0);
    send_a(16'h3E00, 4'd3, 0);
    send_a(16'h3D80, 4'd4, 0);
    send_a(16'h4080, 4'd5, 0);
    send_a(16'h7FC0, 4'd6, 0);
    send_a(16'h0000, 4'd7, 0);
    send_a(16'h407F, 4'd8, 0);
    idle(4);
    check("a_ovf_cnt_edges", 32'(a_oc), 2);
    check("a_neg_cnt_edges", 32'(a_nc), 0);

    // Clear, then the sign cases.
    a_clr = 1'b1;
    idle(1);
    a_clr = 1'b0;
    check("a_ovf_cnt_cleared", 32'(a_oc), 0);
    send_a(16'hC040, 4'd9, 1);
    send_a(16'hC040, 4'd10, 0);
    idle(4);
    check("a_neg_cnt_sign", 32'(a_nc), 2);

    // Backpressure: out_ready low mid-stream.
    lat_mode[0] = 1'b0;
    a_saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send_a(bp_x[i], 4'(i), 1'(i & 1));
      end
      begin
        idle(3);
        a_ordy = 1'b0;
        idle(4);
        a_ordy = 1'b1;
      end
    join
    idle(6);
    check("a_bp_in_ready_dropped", 32'(a_saw_stall), 1);
    check("a_bp_drained", exp_q[0].size(), 0);

    // Reset with both stages full.
    a_ordy = 1'b0;
    send_a(16'h3FC0, 4'd1, 0);
    send_a(16'h4080, 4'd2, 0);
    check("a_full_before_rst", 32'({a_ov, a_ir}), 32'(2'b10));
    #2;
    rst = 1'b1;
    #1;
    check("a_midrst_out_valid", 32'(a_ov), 0);
    check("a_midrst_cnts", {a_oc, a_nc}, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    a_ordy = 1'b1;
    lat_mode[0] = 1'b1;
    send_a(16'h3F20, 4'd3, 0);
    idle(3);
    check("a_post_rst_drained", exp_q[0].size(), 0);

    // Clear coinciding with an ovf handshake.
    send_a(16'h4080, 4'd4, 0);
    send_a(16'h4080, 4'd5, 0);
    idle(1);
    check("a_ovf_before_clr", 32'(a_oc), 1);
    check("a_clr_hs", 32'({a_ov, a_ordy, a_fo, a_otag}), 32'({3'b111, 4'd5}));
    a_clr = 1'b1;
    idle(1);
    a_clr = 1'b0;
    check("a_clr_wins", 32'(a_oc), 0);

    // Parameter sweep and counter saturation on unit B.
    send_b(16'h3FE0, 4'd0, 0);
    send_b(16'h3F40, 4'd1, 0);
    send_b(16'h3E9A, 4'd2, 0);
    send_b(16'h3E4D, 4'd3, 0);
    send_b(16'hBFE0, 4'd4, 1);
    for (int i = 0; i < 5; i++) send_b(16'h7F80, 4'(5 + i), 0);
    idle(4);
    check("b_ovf_saturated", 32'(b_oc), 3);
    check("b_neg_cnt", 32'(b_nc), 1);
    check("b_drained", exp_q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
